uart_tx_engine: RTL and testbench

//  Serial UART transmitter, directly downstream of the UART config register file. Consumes

---
 rtl/uart_tx_engine.sv | 146 ++++++++++++++
 tb/tb_uart_tx_engine.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// Serial UART transmitter with phase-accumulator baud timing; frame starts the cycle after accept.
// Backpressure: tx_ready only in IDLE, enabled, with no rate update pending; tx/busy are registered.
module uart_tx_engine #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int RESET_RATE = 9600,
  parameter int DATA_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_enable,
  input  logic [2:0]  uart_mode,
  input  logic [15:0] uart_rate,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        tx,
  output logic        uart_busy,
  output logic        uart_error,
  output logic        update_ok
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [ACC_W-1:0] CLK_ACC  = ACC_W'(CLK_HZ);
  localparam logic [31:0]      MAX_RATE = 32'(CLK_HZ / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
  logic [15:0]          active_rate_q, active_rate_d, prev_rate_q;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 par_en_q, par_en_d, stop2_q, stop2_d, parity_q, parity_d;
  logic                 tx_q, tx_d, busy_q, busy_d, error_q, error_d, update_q, update_d;
  logic                 rate_valid, pending, accept, tick, rate_err;

  assign rate_valid = (uart_rate != 16'd0) && (32'(uart_rate) <= MAX_RATE);
  assign pending    = rate_valid && (uart_rate != active_rate_q);
  assign rate_err   = (uart_rate != prev_rate_q) && !rate_valid;
  assign tx_ready   = (state_q == IDLE) && uart_enable && !pending;
  assign accept     = tx_valid && tx_ready;
  // active_rate <= CLK_HZ/2 keeps acc+rate below 1.5*CLK_HZ, inside ACC_W bits
  assign acc_sum    = acc_q + ACC_W'(active_rate_q);
  assign tick       = (acc_sum >= CLK_ACC);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    active_rate_d = active_rate_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    par_en_d      = par_en_q;
    stop2_d       = stop2_q;
    parity_d      = parity_q;
    update_d      = 1'b0;
    error_d       = rate_err;
    case (state_q)
      IDLE: begin
        if (pending) begin
          active_rate_d = uart_rate;
          update_d      = 1'b1;
        end else if (accept) begin
          state_d   = START;
          acc_d     = '0;
          bit_cnt_d = '0;
          shreg_d   = tx_data[DATA_BITS-1:0];
          par_en_d  = uart_mode[0];
          stop2_d   = uart_mode[2];
          parity_d  = (^tx_data[DATA_BITS-1:0]) ^ uart_mode[1];
        end
      end
      default: begin
        if (!uart_enable) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          acc_d = tick ? (acc_sum - CLK_ACC) : acc_sum;
          if (tick) begin
            case (state_q)
              START: state_d = DATA;
              DATA: begin
                if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
                end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shreg_d   = shreg_q >> 1;
                end
              end
              PARITY:  state_d = STOP;
              STOP:    state_d = stop2_q ? STOP2 : IDLE;
              default: state_d = IDLE;
            endcase
          end
        end
      end
    endcase

    // Line level is registered from the state being entered
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      active_rate_q <= 16'(RESET_RATE);
      prev_rate_q   <= 16'(RESET_RATE);
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      par_en_q      <= 1'b0;
      stop2_q       <= 1'b0;
      parity_q      <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      update_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      active_rate_q <= active_rate_d;
      prev_rate_q   <= uart_rate;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      par_en_q      <= par_en_d;
      stop2_q       <= stop2_d;
      parity_q      <= parity_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      update_q      <= update_d;
    end
  end

  assign tx         = tx_q;
  assign uart_busy  = busy_q;
  assign uart_error = error_q;
  assign update_ok  = update_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine at CLK_HZ=38400: expected line bits are queued per frame and
// popped cycle by cycle as the DUT shifts them out.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        uart_enable = 1'b0;
  logic [2:0]  uart_mode = 3'b000;
  logic [15:0] uart_rate = 16'd9600;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, tx, uart_busy, uart_error, update_ok;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int upd_cnt = 0;
  int both_cnt = 0;
  logic bit_q[$];

  uart_tx_engine #(.CLK_HZ(38400), .RESET_RATE(9600), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .uart_enable(uart_enable), .uart_mode(uart_mode),
    .uart_rate(uart_rate), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx(tx), .uart_busy(uart_busy), .uart_error(uart_error), .update_ok(update_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (uart_error) err_cnt++;
    if (update_ok) upd_cnt++;
    if (uart_error && update_ok) both_cnt++;
  end

  task automatic accept(input logic [7:0] d, input logic [2:0] m, output int waits);
    waits = 0;
    tx_data = d;
    uart_mode = m;
    tx_valid = 1'b1;
    #1;
    while (!tx_ready && waits < 200) begin
      @(negedge clk); #1;
      waits++;
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_timeout: tx_ready=%b, required 1", tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    uart_mode = ~m;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [2:0] m, input int cpb,
                           input int mid_rate, output int waits);
    int busy_n, exp_busy, cyc;
    logic exp_b;
    bit_q.delete();
    bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
    if (m[0]) bit_q.push_back((^d) ^ m[1]);
    bit_q.push_back(1'b1);
    if (m[2]) bit_q.push_back(1'b1);
    exp_busy = bit_q.size() * cpb;
    accept(d, m, waits);
    busy_n = 0;
    cyc = 0;
    while (bit_q.size() > 0) begin
      exp_b = bit_q.pop_front();
      for (int c = 0; c < cpb; c++) begin
        n_cmp++;
        if (tx !== exp_b) begin
          n_bad++;
          $display("FAIL frame_bit d=%h mode=%b cyc=%0d: tx=%b, required %b", d, m, cyc, tx, exp_b);
        end
        if (uart_busy === 1'b1) busy_n++;
        if (mid_rate >= 0 && cyc == 6) uart_rate = 16'(mid_rate);
        cyc++;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (busy_n != exp_busy) begin
      n_bad++;
      $display("FAIL busy_cycles d=%h mode=%b: got %0d, required %0d", d, m, busy_n, exp_busy);
    end
    n_cmp++;
    if (uart_busy !== 1'b0 || tx !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_end d=%h: busy=%b tx=%b, required busy=0 tx=1", d, uart_busy, tx);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx, uart_busy, uart_error, update_ok, tx_ready} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_outputs: tx,busy,err,upd,rdy=%b, required 10000",
               {tx, uart_busy, uart_error, update_ok, tx_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b0 || uart_error !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_disabled: tx_ready=%b err=%b, required 0 0", tx_ready, uart_error);
    end
    uart_enable = 1'b1;
    #1;
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_enabled: tx_ready=%b, required 1", tx_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int w;
    run_frame(8'hA5, 3'b000, 4, -1, w);
  endtask

  task automatic test_parity_stop();
    int w;
    run_frame(8'hA5, 3'b001, 4, -1, w);
    run_frame(8'hA5, 3'b011, 4, -1, w);
    run_frame(8'hA5, 3'b100, 4, -1, w);
  endtask

  task automatic test_back_to_back();
    int w;
    run_frame(8'h81, 3'b000, 4, -1, w);
    run_frame(8'h7E, 3'b000, 4, -1, w);
    n_cmp++;
    if (w != 0) begin
      n_bad++;
      $display("FAIL back_to_back_wait: waited %0d cycles, required 0", w);
    end
  endtask

  task automatic test_rate_update();
    int w, u0;
    uart_rate = 16'd4800;
    #1;
    n_cmp++;
    if (tx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_pending: tx_ready=%b, required 0", tx_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (update_ok !== 1'b1 || uart_error !== 1'b0) begin
      n_bad++;
      $display("FAIL update_pulse: upd=%b err=%b, required 1 0", update_ok, uart_error);
    end
    @(negedge clk);
    n_cmp++;
    if (update_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL update_single: upd=%b, required 0", update_ok);
    end
    run_frame(8'h5A, 3'b000, 8, -1, w);
    uart_rate = 16'd9600;
    @(negedge clk);
    n_cmp++;
    if (update_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL update_restore: upd=%b, required 1", update_ok);
    end
    @(negedge clk);
    u0 = upd_cnt;
    run_frame(8'h0F, 3'b000, 4, 4800, w);
    n_cmp++;
    if (upd_cnt != u0) begin
      n_bad++;
      $display("FAIL update_deferred: %0d pulses in frame, required 0", upd_cnt - u0);
    end
    @(negedge clk);
    n_cmp++;
    if (update_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL update_after_frame: upd=%b, required 1", update_ok);
    end
    uart_rate = 16'd9600;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_rate_priority();
    int w;
    uart_rate = 16'd4800;
    run_frame(8'hA5, 3'b000, 8, -1, w);
    n_cmp++;
    if (w != 1) begin
      n_bad++;
      $display("FAIL rate_priority_wait: waited %0d cycles, required 1", w);
    end
    uart_rate = 16'd9600;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_invalid_rate();
    int w;
    uart_rate = 16'd0;
    @(negedge clk);
    n_cmp++;
    if (uart_error !== 1'b1 || update_ok !== 1'b0 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rate_zero: err=%b upd=%b rdy=%b, required 1 0 1", uart_error, update_ok, tx_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (uart_error !== 1'b0) begin
      n_bad++;
      $display("FAIL rate_zero_single: err=%b, required 0", uart_error);
    end
    uart_rate = 16'd30000;
    @(negedge clk);
    n_cmp++;
    if (uart_error !== 1'b1 || update_ok !== 1'b0 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rate_high: err=%b upd=%b rdy=%b, required 1 0 1", uart_error, update_ok, tx_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (uart_error !== 1'b0) begin
      n_bad++;
      $display("FAIL rate_high_single: err=%b, required 0", uart_error);
    end
    uart_rate = 16'd9600;
    @(negedge clk);
    n_cmp++;
    if (uart_error !== 1'b0 || update_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL rate_back: err=%b upd=%b, required 0 0", uart_error, update_ok);
    end
    run_frame(8'hA5, 3'b000, 4, -1, w);
  endtask

  task automatic test_enable_drop();
    int w;
    accept(8'hC3, 3'b000, w);
    repeat (17) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_bit3: tx=%b, required 0", tx);
    end
    uart_enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({tx, uart_busy, uart_error, tx_ready} !== 4'b1010) begin
      n_bad++;
      $display("FAIL drop_abort: tx,busy,err,rdy=%b, required 1010", {tx, uart_busy, uart_error, tx_ready});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx, uart_busy, uart_error, tx_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL drop_idle: tx,busy,err,rdy=%b, required 1000", {tx, uart_busy, uart_error, tx_ready});
    end
    uart_enable = 1'b1;
    #1;
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_reenable: tx_ready=%b, required 1", tx_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int w, u0, e0;
    uart_rate = 16'd4800;
    @(negedge clk);
    @(negedge clk);
    accept(8'h5A, 3'b000, w);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    uart_rate = 16'd9600;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || uart_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: tx=%b busy=%b, required 1 0", tx, uart_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    u0 = upd_cnt;
    e0 = err_cnt;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (upd_cnt != u0 || err_cnt != e0 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_rate: upd=%0d err=%0d rdy=%b, required 0 0 1", upd_cnt - u0, err_cnt - e0, tx_ready);
    end
    run_frame(8'h3C, 3'b000, 4, -1, w);
  endtask

  task automatic test_no_overlap();
    n_cmp++;
    if (both_cnt != 0) begin
      n_bad++;
      $display("FAIL err_upd_overlap: %0d cycles, required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_stop();
    test_back_to_back();
    test_rate_update();
    test_rate_priority();
    test_invalid_rate();
    test_enable_drop();
    test_reset_mid_frame();
    test_no_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
